// File: rtl/reto_line_printer_pkg.sv
// Shared constants for the thermal line printer: UART timing, print FSM
// encoding and the stepper full-step phase table.
package reto_line_printer_pkg;

  localparam int unsigned DEF_CLK_HZ = 50_000_000;
  localparam int unsigned DEF_BAUD   = 9600;
  localparam int unsigned BIT_PERIOD = DEF_CLK_HZ / DEF_BAUD;
  localparam int unsigned HALF_BIT   = BIT_PERIOD / 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SHIFT  = 3'd1;
  localparam logic [2:0] ST_LATCH  = 3'd2;
  localparam logic [2:0] ST_STROBE = 3'd3;
  localparam logic [2:0] ST_FEED   = 3'd4;

  // Coil order is {INA, INB, INA2, INB2}
  typedef logic [3:0] coil_t;

  function automatic int unsigned calc_bit_period(input int unsigned clk_hz,
                                                  input int unsigned baud);
    return clk_hz / baud;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic coil_t step_coils(input logic [1:0] phase);
    coil_t c;
    case (phase)
      2'd0:    c = 4'b1100;
      2'd1:    c = 4'b0110;
      2'd2:    c = 4'b0011;
      default: c = 4'b1001;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/reto_line_printer_if.sv
// Board-side pins of the line printer: UART input, head and stepper outputs.
interface reto_line_printer_if;

  logic Rx;
  logic DO;
  logic CLKimpr;
  logic LAT;
  logic STB;
  logic INA;
  logic INB;
  logic INA2;
  logic INB2;
  logic overflow;

  modport master (input Rx,
                  output DO, CLKimpr, LAT, STB, INA, INB, INA2, INB2, overflow);

  modport slave  (output Rx,
                  input DO, CLKimpr, LAT, STB, INA, INB, INA2, INB2, overflow);

endinterface

// File: rtl/reto_uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, start glitch
// rejection and framing check. Emits a one-cycle byte_valid per good byte.
module reto_uart_rx
  import reto_line_printer_pkg::*;
#(
  parameter int unsigned BIT_CYC  = BIT_PERIOD,
  parameter int unsigned HALF_CYC = HALF_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] data_out
);

  localparam int unsigned CNT_W = $clog2(BIT_CYC);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic             rx_meta, rx_sync, rx_prev;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      data_out   <= '0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        // A start bit that is already high again at mid-bit was only a glitch
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift   <= {rx_sync, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              data_out   <= shift;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/reto_line_printer.sv
// Thermal line printer controller: assembles UART bytes into 256-dot lines,
// shifts/latches/strobes them into the head and feeds paper one line.
module reto_line_printer
  import reto_line_printer_pkg::*;
#(
  parameter int unsigned CLK_HZ         = DEF_CLK_HZ,
  parameter int unsigned BAUD           = DEF_BAUD,
  parameter int unsigned LINE_BYTES     = 32,
  parameter int unsigned SCLK_HALF      = 25,
  parameter int unsigned LAT_CYCLES     = 50,
  parameter int unsigned STB_CYCLES     = 100_000,
  parameter int unsigned STEP_CYCLES    = 100_000,
  parameter int unsigned STEPS_PER_LINE = 4
) (
  input logic                 CLK,
  input logic                 RST,
  reto_line_printer_if.master bus
);

  localparam int unsigned RX_BIT    = calc_bit_period(CLK_HZ, BAUD);
  localparam int unsigned LINE_BITS = LINE_BYTES * 8;
  localparam int unsigned TIMER_MAX = max2(max2(STB_CYCLES, STEP_CYCLES),
                                           max2(2 * SCLK_HALF, LAT_CYCLES));
  localparam int unsigned CW = $clog2(LINE_BYTES);
  localparam int unsigned BW = $clog2(LINE_BITS);
  localparam int unsigned SW = $clog2(STEPS_PER_LINE + 1);
  localparam int unsigned TW = $clog2(TIMER_MAX);

  localparam logic [CW-1:0] BYTE_LAST  = CW'(LINE_BYTES - 1);
  localparam logic [BW-1:0] BITS_LAST  = BW'(LINE_BITS - 1);
  localparam logic [SW-1:0] STEPS_LAST = SW'(STEPS_PER_LINE - 1);
  localparam logic [TW-1:0] SCLK_RISE  = TW'(SCLK_HALF - 1);
  localparam logic [TW-1:0] SCLK_END   = TW'(2 * SCLK_HALF - 1);
  localparam logic [TW-1:0] LAT_LAST   = TW'(LAT_CYCLES - 1);
  localparam logic [TW-1:0] STB_LAST   = TW'(STB_CYCLES - 1);
  localparam logic [TW-1:0] STEP_LAST  = TW'(STEP_CYCLES - 1);

  logic                 byte_valid;
  logic [7:0]           rx_byte;
  logic [7:0]           line_mem [LINE_BYTES];
  logic [LINE_BITS-1:0] line_next;
  logic [LINE_BITS-1:0] shreg;
  logic [CW-1:0]        count;
  logic                 line_done;
  logic                 overflow;
  logic [2:0]           state;
  logic [TW-1:0]        timer;
  logic [BW-1:0]        bit_cnt;
  logic [SW-1:0]        step_cnt;
  logic [1:0]           phase;
  logic                 do_q, sclk_q, lat_q, stb_q;
  coil_t                coils;

  reto_uart_rx #(
    .BIT_CYC  (RX_BIT),
    .HALF_CYC (RX_BIT / 2)
  ) u_rx (
    .clk        (CLK),
    .rst        (RST),
    .rx         (bus.Rx),
    .byte_valid (byte_valid),
    .data_out   (rx_byte)
  );

  always_ff @(posedge CLK) begin
    if (byte_valid) line_mem[count] <= rx_byte;
  end

  // Full line including the byte arriving this cycle, byte 0 in the MSBs
  always_comb begin
    line_next = '0;
    for (int i = 0; i < int'(LINE_BYTES); i++) begin
      line_next[(LINE_BYTES - 1 - i) * 8 +: 8] = (CW'(i) == count) ? rx_byte : line_mem[i];
    end
  end

  assign line_done = byte_valid && (count == BYTE_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      count    <= '0;
      overflow <= 1'b0;
      state    <= ST_IDLE;
      timer    <= '0;
      bit_cnt  <= '0;
      step_cnt <= '0;
      phase    <= '0;
      shreg    <= '0;
      do_q     <= 1'b0;
      sclk_q   <= 1'b0;
      lat_q    <= 1'b1;
      stb_q    <= 1'b0;
      coils    <= '0;
    end else begin
      if (byte_valid) count <= (count == BYTE_LAST) ? '0 : count + 1'b1;
      if (line_done && state != ST_IDLE) overflow <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (line_done) begin
            do_q    <= line_next[LINE_BITS-1];
            shreg   <= line_next << 1;
            timer   <= '0;
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end
        end
        // DO is only ever changed together with the falling shift clock
        ST_SHIFT: begin
          if (timer == SCLK_RISE) begin
            sclk_q <= 1'b1;
            timer  <= timer + 1'b1;
          end else if (timer == SCLK_END) begin
            sclk_q <= 1'b0;
            timer  <= '0;
            if (bit_cnt == BITS_LAST) begin
              do_q  <= 1'b0;
              lat_q <= 1'b0;
              state <= ST_LATCH;
            end else begin
              do_q    <= shreg[LINE_BITS-1];
              shreg   <= shreg << 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_LATCH: begin
          if (timer == LAT_LAST) begin
            timer <= '0;
            lat_q <= 1'b1;
            stb_q <= 1'b1;
            state <= ST_STROBE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_STROBE: begin
          if (timer == STB_LAST) begin
            timer    <= '0;
            stb_q    <= 1'b0;
            coils    <= step_coils(phase);
            step_cnt <= '0;
            state    <= ST_FEED;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        // Phase keeps advancing across lines; coils de-energize between lines
        ST_FEED: begin
          if (timer == STEP_LAST) begin
            timer <= '0;
            phase <= phase + 2'd1;
            if (step_cnt == STEPS_LAST) begin
              coils <= '0;
              state <= ST_IDLE;
            end else begin
              step_cnt <= step_cnt + 1'b1;
              coils    <= step_coils(phase + 2'd1);
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.DO       = do_q;
  assign bus.CLKimpr  = sclk_q;
  assign bus.LAT      = lat_q;
  assign bus.STB      = stb_q;
  assign bus.overflow = overflow;
  assign {bus.INA, bus.INB, bus.INA2, bus.INB2} = coils;

endmodule

// File: tb/tb_reto_line_printer.sv
// Self-checking bench for reto_line_printer: UART byte stream in, printed
// lines, latch/strobe pulses and stepper sequence compared against a model.
module tb_reto_line_printer;

  localparam int CLK_HZ      = 1200;
  localparam int BAUD        = 100;
  localparam int SCLK_HALF   = 2;
  localparam int LAT_CYCLES  = 3;
  localparam int STB_CYCLES  = 20;
  localparam int STEP_CYCLES = 10;
  localparam int STEPS       = 4;
  localparam int BIT_NS      = (CLK_HZ / BAUD) * 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reto_line_printer_if bus ();

  reto_line_printer #(
    .CLK_HZ         (CLK_HZ),
    .BAUD           (BAUD),
    .LINE_BYTES     (32),
    .SCLK_HALF      (SCLK_HALF),
    .LAT_CYCLES     (LAT_CYCLES),
    .STB_CYCLES     (STB_CYCLES),
    .STEP_CYCLES    (STEP_CYCLES),
    .STEPS_PER_LINE (STEPS)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: accepted bytes grouped into expected 256-dot lines
  logic [7:0]   model_q [$];
  logic [255:0] exp_lines [$];
  logic [3:0]   phase_seq [4];
  int           step_idx = 0;

  // Observed behaviour, collected on the falling clock edge
  logic [255:0] cap_bits;
  int           cap_n, rise_count, lat_len, stb_len, coil_len;
  logic         prev_sclk, prev_lat, prev_stb;
  logic [3:0]   prev_coil;
  logic [3:0]   coil_now;
  logic [255:0] cap_lines [$];
  int           cap_lens [$];
  int           lat_widths [$];
  int           stb_widths [$];
  logic [3:0]   step_vals [$];
  int           step_lens [$];

  assign coil_now = {bus.INA, bus.INB, bus.INA2, bus.INB2};

  always @(negedge clk) begin
    if (bus.CLKimpr === 1'b1 && prev_sclk === 1'b0) begin
      cap_bits = {cap_bits[254:0], bus.DO};
      cap_n++;
      rise_count++;
    end
    if (bus.LAT === 1'b0) lat_len++;
    if (bus.LAT === 1'b0 && prev_lat === 1'b1) begin
      cap_lines.push_back(cap_bits);
      cap_lens.push_back(cap_n);
      cap_bits = '0;
      cap_n    = 0;
    end
    if (bus.LAT === 1'b1 && prev_lat === 1'b0) begin
      lat_widths.push_back(lat_len);
      lat_len = 0;
    end
    if (bus.STB === 1'b1) stb_len++;
    if (bus.STB === 1'b0 && prev_stb === 1'b1) begin
      stb_widths.push_back(stb_len);
      stb_len = 0;
    end
    if (coil_now !== prev_coil) begin
      if (prev_coil !== 4'b0000) begin
        step_vals.push_back(prev_coil);
        step_lens.push_back(coil_len);
      end
      coil_len = 1;
    end else begin
      coil_len++;
    end
    prev_sclk = bus.CLKimpr;
    prev_lat  = bus.LAT;
    prev_stb  = bus.STB;
    prev_coil = coil_now;
  end

  task automatic flush_capture();
    cap_bits   = '0;
    cap_n      = 0;
    rise_count = 0;
    lat_len    = 0;
    stb_len    = 0;
    coil_len   = 0;
    prev_sclk  = bus.CLKimpr;
    prev_lat   = bus.LAT;
    prev_stb   = bus.STB;
    prev_coil  = coil_now;
    cap_lines.delete();
    cap_lens.delete();
    lat_widths.delete();
    stb_widths.delete();
    step_vals.delete();
    step_lens.delete();
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_line(input string tag, input logic [255:0] observed,
                            input logic [255:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [255:0] v;
    model_q.push_back(b);
    if (model_q.size() == 32) begin
      v = '0;
      foreach (model_q[i]) v = {v[247:0], model_q[i]};
      exp_lines.push_back(v);
      model_q.delete();
    end
  endtask

  // Drives one 8N1 frame; a bad stop bit is followed by one idle bit time
  task automatic apply_stimulus(input logic [7:0] b, input logic stop);
    bus.Rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      bus.Rx = b[i];
      #(BIT_NS);
    end
    bus.Rx = stop;
    #(BIT_NS);
    bus.Rx = 1'b1;
    if (!stop) #(BIT_NS);
    if (stop) model_byte(b);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_DO"},      32'(bus.DO),      32'd0);
    check_output({tag, "_CLKimpr"}, 32'(bus.CLKimpr), 32'd0);
    check_output({tag, "_LAT"},     32'(bus.LAT),     32'd1);
    check_output({tag, "_STB"},     32'(bus.STB),     32'd0);
    check_output({tag, "_coils"},   32'(coil_now),    32'd0);
  endtask

  task automatic wait_prints(input int n_lines);
    int c;
    c = 0;
    while (c < 6000 && step_vals.size() < n_lines * STEPS) begin
      @(posedge clk);
      c++;
    end
    repeat (5) @(posedge clk);
    #1;
    check_output("print_done", 32'(step_vals.size() >= n_lines * STEPS), 32'd1);
  endtask

  task automatic check_lines();
    int n;
    n = exp_lines.size();
    check_output("lines_printed", 32'(cap_lines.size()), 32'(n));
    check_output("lat_pulses",    32'(lat_widths.size()), 32'(n));
    check_output("stb_pulses",    32'(stb_widths.size()), 32'(n));
    check_output("feed_steps",    32'(step_vals.size()),  32'(n * STEPS));
    for (int i = 0; i < n; i++) begin
      if (i < cap_lines.size()) begin
        check_line("line_dots", cap_lines[i], exp_lines[i]);
        check_output("dot_clocks", 32'(cap_lens[i]), 32'd256);
      end
      if (i < lat_widths.size()) check_output("lat_width", 32'(lat_widths[i]), 32'(LAT_CYCLES));
      if (i < stb_widths.size()) check_output("stb_width", 32'(stb_widths[i]), 32'(STB_CYCLES));
    end
    for (int k = 0; k < step_vals.size(); k++) begin
      check_output("step_coils", 32'(step_vals[k]), 32'(phase_seq[step_idx % 4]));
      check_output("step_dwell", 32'(step_lens[k]), 32'(STEP_CYCLES));
      step_idx++;
    end
    check_output("coils_idle", 32'(coil_now), 32'd0);
    check_output("overflow",   32'(bus.overflow), 32'd0);
    flush_capture();
    exp_lines.delete();
  endtask

  task automatic random_line();
    for (int i = 0; i < 32; i++) apply_stimulus(8'($urandom_range(0, 255)), 1'b1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst    = 1'b1;
    bus.Rx = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("rst_next_edge");
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_q.delete();
    exp_lines.delete();
    flush_capture();
  endtask

  initial begin
    int c;
    phase_seq = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
    rst    = 1'b1;
    bus.Rx = 1'b1;
    @(posedge clk);
    #1;
    flush_capture();
    repeat (100) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check_output("reset_no_sclk", 32'(rise_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_output("idle_no_sclk", 32'(rise_count), 32'd0);

    $display("[TB] line of 0xFF");
    for (int i = 0; i < 32; i++) apply_stimulus(8'hFF, 1'b1);
    wait_prints(1);
    check_lines();

    $display("[TB] seven back-to-back random lines");
    for (int l = 0; l < 7; l++) random_line();
    wait_prints(7);
    check_lines();

    $display("[TB] pattern line 0x80 .. 0x01");
    apply_stimulus(8'h80, 1'b1);
    for (int i = 0; i < 30; i++) apply_stimulus(8'h00, 1'b1);
    apply_stimulus(8'h01, 1'b1);
    wait_prints(1);
    check_lines();

    $display("[TB] start glitch and framing error");
    bus.Rx = 1'b0;
    #40;
    bus.Rx = 1'b1;
    #(2 * BIT_NS);
    for (int i = 0; i < 5; i++) apply_stimulus(8'($urandom_range(0, 255)), 1'b1);
    apply_stimulus(8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 26; i++) apply_stimulus(8'($urandom_range(0, 255)), 1'b1);
    repeat (1500) @(posedge clk);
    #1;
    check_output("no_early_print", 32'(rise_count), 32'd0);
    apply_stimulus(8'($urandom_range(0, 255)), 1'b1);
    wait_prints(1);
    check_lines();

    $display("[TB] reset during strobe");
    random_line();
    c = 0;
    while (c < 6000 && bus.STB !== 1'b1) begin
      @(negedge clk);
      c++;
    end
    check_output("stb_seen", 32'(bus.STB), 32'd1);
    repeat (5) @(posedge clk);
    pulse_reset();
    repeat (50) @(posedge clk);
    #1;
    check_output("no_feed_after_rst", 32'(step_vals.size()), 32'd0);
    check_output("no_stb_after_rst",  32'(bus.STB), 32'd0);

    $display("[TB] reset during feed");
    random_line();
    c = 0;
    while (c < 6000 && coil_now === 4'b0000) begin
      @(negedge clk);
      c++;
    end
    check_output("feed_seen", 32'(coil_now !== 4'b0000), 32'd1);
    pulse_reset();

    $display("[TB] reset during 10th byte");
    for (int i = 0; i < 9; i++) apply_stimulus(8'($urandom_range(0, 255)), 1'b1);
    bus.Rx = 1'b0;
    #(3 * BIT_NS);
    pulse_reset();
    random_line();
    wait_prints(1);
    check_lines();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
